keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_debounce.sv | 35 +++
 rtl/keypad_scanner.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHold,
    StRelease
  } keypad_state_e;

  // Repeat timing as multiples of the debounce period.
  localparam int unsigned RepeatFirstMult = 16;
  localparam int unsigned RepeatNextMult  = 4;

  function automatic int unsigned cnt_width(input int unsigned scan_cycles,
                                            input int unsigned debounce_cycles);
    int unsigned m;
    m = (scan_cycles > debounce_cycles) ? scan_cycles : debounce_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Saturating stable-level counter; flags the Cycles-th consecutive cycle of 'level'.
module keypad_debounce #(
  parameter int unsigned Cycles = 4096,
  parameter int unsigned CntW   = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic level,
  output logic stable
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !level) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the caller can act on the same cycle the count completes.
  assign stable = level && !clear && (cnt_q >= CntW'(Cycles - 1));

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounce, ready/valid key output and sticky overrun.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_CYCLES     = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          EN,
  input  logic [ROWS-1:0]               ROW_IN,
  output logic [COLS-1:0]               COL_OUT,
  output logic [$clog2(ROWS*COLS)-1:0]  KEY_CODE,
  output logic                          KEY_VALID,
  input  logic                          KEY_READY,
  output logic                          KEY_HELD,
  output logic                          OVERRUN
);

  localparam int unsigned CW   = code_width(ROWS, COLS);
  localparam int unsigned CntW = cnt_width(SCAN_CYCLES, DEBOUNCE_CYCLES);
  localparam int unsigned RowW = idx_width(ROWS);
  localparam int unsigned ColW = idx_width(COLS);

  keypad_state_e   state_q, state_d;
  logic [ColW-1:0] col_q, col_d, next_col;
  logic [RowW-1:0] row_q, row_d, low_row;
  logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
  logic [CW-1:0]   code_q, code_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            row_level, deb_clear, deb_level, deb_done;
  logic            key_load, rpt_fire;

  assign row_level = ROW_IN[row_q];
  assign next_col  = (col_q == ColW'(COLS - 1)) ? '0 : col_q + ColW'(1);

  // Lowest-index active row wins when several are pressed.
  always_comb begin
    low_row = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (ROW_IN[i]) low_row = RowW'(i);
    end
  end

  // One counter serves both press (row high) and release (row low) qualification.
  assign deb_clear = !EN || !(state_q == StDebounce || state_q == StRelease);
  assign deb_level = (state_q == StRelease) ? !row_level : row_level;

  keypad_debounce #(
    .Cycles (DEBOUNCE_CYCLES),
    .CntW   (CntW)
  ) u_debounce (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clear  (deb_clear),
    .level  (deb_level),
    .stable (deb_done)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RptFirst = RepeatFirstMult * DEBOUNCE_CYCLES;
  localparam int unsigned RptNext  = RepeatNextMult * DEBOUNCE_CYCLES;
  localparam int unsigned RptW     = $clog2(RptFirst + 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;

  assign rpt_fire = (state_q == StHold) && (rpt_cnt_q == RptW'(RptFirst - 1));

  // After a repeat, rewind so the next one lands RptNext cycles later.
  always_comb begin
    if (!EN || state_q != StHold) begin
      rpt_cnt_d = '0;
    end else if (rpt_fire) begin
      rpt_cnt_d = RptW'(RptFirst - RptNext);
    end else begin
      rpt_cnt_d = rpt_cnt_q + RptW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StScan;
      col_q      <= '0;
      row_q      <= '0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    key_load   = 1'b0;
    if (!EN) begin
      state_d    = StScan;
      col_d      = '0;
      scan_cnt_d = '0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (scan_cnt_q >= CntW'(SCAN_CYCLES - 1)) begin
            scan_cnt_d = '0;
            if (|ROW_IN) begin
              state_d = StDebounce;
              row_d   = low_row;
            end else begin
              col_d = next_col;
            end
          end else if (scan_cnt_q != '1) begin
            scan_cnt_d = scan_cnt_q + CntW'(1);
          end
        end
        StDebounce: begin
          if (!row_level) begin
            state_d = StScan;
            col_d   = next_col;
          end else if (deb_done) begin
            state_d  = StHold;
            key_load = 1'b1;
          end
        end
        StHold: begin
          if (!row_level) begin
            state_d = StRelease;
          end else if (rpt_fire) begin
            key_load = 1'b1;
          end
        end
        StRelease: begin
          if (row_level) begin
            state_d = StHold;
          end else if (deb_done) begin
            state_d = StScan;
            col_d   = next_col;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // A handshake in the same cycle as a load frees the slot, so no overrun.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && KEY_READY) valid_d = 1'b0;
    if (key_load) begin
      if (!valid_q || KEY_READY) begin
        code_d  = CW'(int'(row_q) * int'(COLS) + int'(col_q));
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    COL_OUT   = EN ? (COLS'(1) << col_q) : '0;
    KEY_HELD  = (state_q == StHold) || (state_q == StRelease);
    KEY_CODE  = code_q;
    KEY_VALID = valid_q;
    OVERRUN   = overrun_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (4x4, 4-cycle dwell, 8-cycle debounce).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS            (4),
    .COLS            (4),
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .EN        (en),
    .ROW_IN    (row_in),
    .COL_OUT   (col_out),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_READY (key_ready),
    .KEY_HELD  (key_held),
    .OVERRUN   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at k=0: 1 time unit after the edge where reset is released.
  task automatic do_reset();
    rst_n  = 1'b0;
    row_in = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Key 5 then key 10 while the consumer stalls; optionally handshake on the second load.
  task automatic run_two_keys(input bit hs_at_load);
    do_reset();
    key_ready = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      step();
      if (k == 4)  row_in = 4'b0010;
      if (k == 20) row_in = 4'b0000;
      if (k == 29) row_in = 4'b0100;
      if (k == 45) row_in = 4'b0000;
      if (k == 40 && hs_at_load) key_ready = 1'b1;
      if (k == 50) key_ready = 1'b1;
      if (k == 16) begin
        check_eq("k5_code", 32'(key_code), 5);
        check_eq("k5_valid", 32'(key_valid), 1);
      end
      if (k == 40) check_eq("pre_load_ovr", 32'(overrun), 0);
      if (!hs_at_load) begin
        if (k == 41) begin
          check_eq("ovr_set", 32'(overrun), 1);
          check_eq("ovr_code_kept", 32'(key_code), 5);
          check_eq("ovr_valid", 32'(key_valid), 1);
        end
        if (k == 50) check_eq("stall_valid", 32'(key_valid), 1);
        if (k == 51) begin
          check_eq("hs_valid_clr", 32'(key_valid), 0);
          check_eq("hs_code", 32'(key_code), 5);
        end
        if (k == 56) begin
          check_eq("ovr_sticky", 32'(overrun), 1);
          check_eq("no_second_valid", 32'(key_valid), 0);
        end
      end else begin
        if (k == 41) begin
          check_eq("hs_load_code", 32'(key_code), 10);
          check_eq("hs_load_valid", 32'(key_valid), 1);
          check_eq("hs_load_ovr", 32'(overrun), 0);
        end
        if (k == 42) check_eq("hs_load_clr", 32'(key_valid), 0);
        if (k == 56) check_eq("hs_load_ovr_end", 32'(overrun), 0);
      end
    end
    key_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nv;
    rst_n     = 1'b0;
    en        = 1'b1;
    row_in    = '0;
    key_ready = 1'b1;

    // Reset values and idle column rotation.
    step();
    check_eq("rst_col", 32'(col_out), 32'h1);
    check_eq("rst_valid", 32'(key_valid), 0);
    check_eq("rst_code", 32'(key_code), 0);
    check_eq("rst_held", 32'(key_held), 0);
    check_eq("rst_ovr", 32'(overrun), 0);
    do_reset();
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      check_eq("idle_col", 32'(col_out), 32'(1 << ((k / 4) % 4)));
      if (key_valid) nv++;
    end
    check_eq("idle_no_valid", nv, 0);

    // Row 2 on column 1, held 20 cycles then released.
    do_reset();
    nv = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 4)  row_in = 4'b0100;
      if (k == 24) row_in = 4'b0000;
      if (key_valid) nv++;
      if (k == 15) check_eq("k9_pre_valid", 32'(key_valid), 0);
      if (k == 16) begin
        check_eq("k9_valid", 32'(key_valid), 1);
        check_eq("k9_code", 32'(key_code), 9);
        check_eq("k9_held", 32'(key_held), 1);
      end
      if (k == 17) check_eq("k9_valid_clr", 32'(key_valid), 0);
      if (k == 32) check_eq("k9_held_rel", 32'(key_held), 1);
      if (k == 33) begin
        check_eq("k9_held_off", 32'(key_held), 0);
        check_eq("k9_next_col", 32'(col_out), 32'h4);
      end
    end
    check_eq("k9_pulses", nv, 1);

    // 5-cycle glitch on row 2 during column 1.
    do_reset();
    nv = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 6)  row_in = 4'b0100;
      if (k == 11) row_in = 4'b0000;
      if (key_valid) nv++;
      if (k == 10) check_eq("glitch_deb_col", 32'(col_out), 32'h2);
      if (k == 12) check_eq("glitch_resume", 32'(col_out), 32'h4);
      if (k == 15) check_eq("glitch_dwell", 32'(col_out), 32'h4);
      if (k == 16) check_eq("glitch_advance", 32'(col_out), 32'h8);
    end
    check_eq("glitch_no_valid", nv, 0);

    run_two_keys(1'b0);
    run_two_keys(1'b1);

    // Rows 1 and 3 on column 0, then enable dropped mid-hold, then reset mid-hold.
    do_reset();
    key_ready = 1'b0;
    row_in    = 4'b1010;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 12) begin
        check_eq("multi_valid", 32'(key_valid), 1);
        check_eq("multi_code", 32'(key_code), 4);
      end
      if (k == 14) begin
        check_eq("multi_held", 32'(key_held), 1);
        en = 1'b0;
        #1;
        check_eq("en_low_col", 32'(col_out), 0);
      end
      if (k == 15) begin
        check_eq("en_low_valid", 32'(key_valid), 1);
        check_eq("en_low_code", 32'(key_code), 4);
        check_eq("en_low_held", 32'(key_held), 0);
        check_eq("en_low_ovr", 32'(overrun), 0);
      end
      if (k == 16) en = 1'b1;
      if (k == 17) check_eq("en_high_col", 32'(col_out), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(key_valid), 0);
    check_eq("midrst_code", 32'(key_code), 0);
    check_eq("midrst_held", 32'(key_held), 0);
    check_eq("midrst_col", 32'(col_out), 32'h1);
    key_ready = 1'b1;
    row_in    = '0;

`ifdef KEYPAD_REPEAT_EN
    begin
      int pos[8];
      int exp_pos[5];
      exp_pos = '{12, 140, 172, 204, 236};
      do_reset();
      row_in = 4'b0001;
      nv = 0;
      for (int k = 1; k <= 280; k++) begin
        step();
        if (k == 262) row_in = 4'b0000;
        if (key_valid) begin
          if (nv < 8) pos[nv] = k;
          nv++;
        end
      end
      check_eq("rpt_count", nv, 5);
      for (int i = 0; i < 5; i++) begin
        if (i < nv) check_eq("rpt_pos", pos[i], exp_pos[i]);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
